mem_port_master: RTL

Requester-side adapter for the team's dual-port simulation/block memory (fixed two-cycle read latency, word-addressed, `en`/`we` strobes, no flow control). It converts a valid/ready request stream from a client (CPU load/store unit, sprite fetcher) into memory port strobes. It tracks in-flight reads, captures `dout` at exactly the right cycle and buffers read data in a small response FIFO so the client can apply backpressure. One instance drives one memory port (`_1` or `_2`).

---
 rtl/mem_port_pkg.sv | 16 +
 rtl/resp_fifo.sv | 60 ++++++
 rtl/mem_port_master.sv | 75 +++++++
 3 files changed

// File: rtl/mem_port_pkg.sv
// Shared types and constants for the memory port requester.
// The in-flight read tracker length follows MEM_READ_LATENCY.
package mem_port_pkg;

  localparam int MEM_READ_LATENCY = 2;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;

  typedef struct packed {
    logic                  write;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/resp_fifo.sv
// Synchronous response FIFO; pointers wrap modulo DEPTH (any DEPTH >= 2).
// Storage is not reset, only pointers and count.
module resp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push_i && (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/mem_port_master.sv
// Valid/ready request stream to fixed-latency memory port strobes, with
// credit-based read tracking and a response FIFO for client backpressure.
module mem_port_master
  import mem_port_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RESP_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [MEM_READ_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
  logic [CNT_W-1:0]            fifo_count;
  logic [OCC_W-1:0]            occupancy_c;
  logic                        accept;
  logic                        pop;

  // Credit: entries already buffered plus reads still inside the memory.
  always_comb begin
    occupancy_c = OCC_W'(fifo_count);
    for (int i = 0; i < MEM_READ_LATENCY; i++) begin
      occupancy_c = occupancy_c + OCC_W'(rd_pipe_q[i]);
    end
  end

  assign req_ready = !reset && (occupancy_c < OCC_W'(RESP_DEPTH));
  assign accept    = req_valid && req_ready;

  assign mem_en   = accept;
  assign mem_we   = accept && req_write;
  assign mem_addr = req_addr;
  assign mem_din  = req_wdata;

  assign rd_pipe_d = {rd_pipe_q[MEM_READ_LATENCY-2:0], accept && !req_write};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rd_pipe_q <= '0;
    else       rd_pipe_q <= rd_pipe_d;
  end

  assign resp_valid = (fifo_count != '0);
  assign pop        = resp_valid && resp_ready;

  resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (DATA_W)
  ) u_resp_fifo (
    .clk_i       (clock),
    .rst_i       (reset),
    .push_i      (rd_pipe_q[MEM_READ_LATENCY-1]),
    .push_data_i (mem_dout),
    .pop_i       (pop),
    .pop_data_o  (resp_rdata),
    .count_o     (fifo_count)
  );

endmodule
